// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, AXI-master and status signals of the shared AXI block port.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512
);
  logic                   i_icache_rd_req;
  logic [ADDR_WIDTH-1:0]  i_icache_addr;
  logic                   o_icache_done;
  logic                   i_dcache_rd_req;
  logic                   i_dcache_wr_req;
  logic [ADDR_WIDTH-1:0]  i_dcache_addr;
  logic [BLOCK_WIDTH-1:0] i_dcache_wr_block;
  logic                   o_dcache_rd_done;
  logic                   o_dcache_wr_done;
  logic [BLOCK_WIDTH-1:0] o_read_block;
  logic                   o_start_read_axi;
  logic                   o_start_write_axi;
  logic [ADDR_WIDTH-1:0]  o_addr_axi;
  logic [BLOCK_WIDTH-1:0] o_data_write_axi;
  logic [BLOCK_WIDTH-1:0] i_data_read_axi;
  logic                   i_read_last_axi;
  logic                   i_b_resp_axi;
  logic                   o_busy;
  logic                   o_protocol_err;
  modport slave (
    input  i_icache_rd_req, i_icache_addr, i_dcache_rd_req, i_dcache_wr_req, i_dcache_addr,
           i_dcache_wr_block, i_data_read_axi, i_read_last_axi, i_b_resp_axi,
    output o_icache_done, o_dcache_rd_done, o_dcache_wr_done, o_read_block, o_start_read_axi,
           o_start_write_axi, o_addr_axi, o_data_write_axi, o_busy, o_protocol_err
  );
  modport master (
    output i_icache_rd_req, i_icache_addr, i_dcache_rd_req, i_dcache_wr_req, i_dcache_addr,
           i_dcache_wr_block, i_data_read_axi, i_read_last_axi, i_b_resp_axi,
    input  o_icache_done, o_dcache_rd_done, o_dcache_wr_done, o_read_block, o_start_read_axi,
           o_start_write_axi, o_addr_axi, o_data_write_axi, o_busy, o_protocol_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the shared AXI block port to icache refill, dcache refill and dcache write-back.
// Define ARB_ROUND_ROBIN_EN to alternate between icache and dcache classes instead of dcache-first priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int BLOCK_WIDTH  = 512,
  parameter int BLOCK_OFFSET = 6
) (
  input logic               clk,
  input logic               arst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  typedef enum logic [1:0] {G_IC, G_DR, G_DW} grant_t;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-BLOCK_OFFSET){1'b1}}, {BLOCK_OFFSET{1'b0}}};
  state_t                 r_state;
  grant_t                 r_grant;
  logic                   r_start_rd;
  logic                   r_start_wr;
  logic                   r_ic_done;
  logic                   r_dr_done;
  logic                   r_dw_done;
  logic                   r_busy;
  logic                   r_err;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BLOCK_WIDTH-1:0] r_wdata;
  logic [BLOCK_WIDTH-1:0] r_rblock;
  logic                   w_dc_req;
  logic                   w_any;
  logic                   w_pick_dc;
  logic                   w_fin;
  logic                   w_err;
  grant_t                 w_grant;
  logic [ADDR_WIDTH-1:0]  w_addr;
`ifdef ARB_ROUND_ROBIN_EN
  logic                   r_rr_dc;
`endif
  always_comb begin
    w_dc_req = bus.i_dcache_wr_req | bus.i_dcache_rd_req;
    w_any = w_dc_req | bus.i_icache_rd_req;
`ifdef ARB_ROUND_ROBIN_EN
    w_pick_dc = w_dc_req & (r_rr_dc | ~bus.i_icache_rd_req);
`else
    w_pick_dc = w_dc_req;
`endif
    w_grant = w_pick_dc ? (bus.i_dcache_wr_req ? G_DW : G_DR) : G_IC;
    w_addr = (w_pick_dc ? bus.i_dcache_addr : bus.i_icache_addr) & ALIGN_MASK;
    w_fin = (r_grant == G_DW) ? bus.i_b_resp_axi : bus.i_read_last_axi;
    // Only the response matching the outstanding transfer type is legal, and only in WAIT.
    w_err = (r_state == WAIT) ? ((r_grant == G_DW) ? bus.i_read_last_axi : bus.i_b_resp_axi)
                              : (bus.i_read_last_axi | bus.i_b_resp_axi);
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= IDLE;
      r_grant    <= G_IC;
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      r_ic_done  <= 1'b0;
      r_dr_done  <= 1'b0;
      r_dw_done  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rblock   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_dc    <= 1'b1;
`endif
    end else begin
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      r_ic_done  <= 1'b0;
      r_dr_done  <= 1'b0;
      r_dw_done  <= 1'b0;
      if (w_err) r_err <= 1'b1;
      case (r_state)
        IDLE: if (w_any) begin
          r_state    <= START;
          r_grant    <= w_grant;
          r_addr     <= w_addr;
          r_start_rd <= w_grant != G_DW;
          r_start_wr <= w_grant == G_DW;
          r_busy     <= 1'b1;
          if (w_grant == G_DW) r_wdata <= bus.i_dcache_wr_block;
`ifdef ARB_ROUND_ROBIN_EN
          r_rr_dc    <= ~w_pick_dc;
`endif
        end
        START: r_state <= WAIT;
        WAIT: if (w_fin) begin
          r_state   <= DONE;
          r_ic_done <= r_grant == G_IC;
          r_dr_done <= r_grant == G_DR;
          r_dw_done <= r_grant == G_DW;
          if (r_grant != G_DW) r_rblock <= bus.i_data_read_axi;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.o_start_read_axi  = r_start_rd;
  assign bus.o_start_write_axi = r_start_wr;
  assign bus.o_icache_done     = r_ic_done;
  assign bus.o_dcache_rd_done  = r_dr_done;
  assign bus.o_dcache_wr_done  = r_dw_done;
  assign bus.o_busy            = r_busy;
  assign bus.o_protocol_err    = r_err;
  assign bus.o_addr_axi        = r_addr;
  assign bus.o_data_write_axi  = r_wdata;
  assign bus.o_read_block      = r_rblock;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus pushes expected start/done events; a negedge monitor pops and compares.
module tb_mem_port_arbiter;
  localparam int SR = 0, SW = 1, ICD = 2, DRD = 3, DWD = 4;
  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0]  addr;
    logic [511:0] data;
  } ev_t;
  logic clk = 1'b0;
  logic arst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];
  localparam logic [511:0] JUNK = {16{32'hDEADBEEF}};
  mem_port_arbiter_if #(.ADDR_WIDTH(64), .BLOCK_WIDTH(512)) bus ();
  mem_port_arbiter #(.ADDR_WIDTH(64), .BLOCK_WIDTH(512), .BLOCK_OFFSET(6)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input int kind, input logic [63:0] a, input logic [511:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc + 1;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask
  // Called in an IDLE cycle with the requests already driven; returns in the next IDLE cycle.
  task automatic serve(input bit wr, input logic [63:0] a, input logic [511:0] wd,
                       input logic [511:0] rd, input int w, input int dkind);
    push(wr ? SW : SR, a, wr ? wd : '0);
    step();
    repeat (w) step();
    if (wr) bus.i_b_resp_axi = 1'b1;
    else begin
      bus.i_read_last_axi = 1'b1;
      bus.i_data_read_axi = rd;
    end
    push(dkind, '0, wr ? '0 : rd);
    step();
    bus.i_b_resp_axi    = 1'b0;
    bus.i_read_last_axi = 1'b0;
    bus.i_data_read_axi = JUNK;
    if (dkind == ICD) bus.i_icache_rd_req = 1'b0;
    if (dkind == DRD) bus.i_dcache_rd_req = 1'b0;
    if (dkind == DWD) bus.i_dcache_wr_req = 1'b0;
    step();
  endtask
  always @(negedge clk) begin
    int   n;
    ev_t  a;
    ev_t  e;
    n = int'(bus.o_start_read_axi) + int'(bus.o_start_write_axi) + int'(bus.o_icache_done)
      + int'(bus.o_dcache_rd_done) + int'(bus.o_dcache_wr_done);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL pulses: %0d start/done pulses in cycle %0d, required at most 1", n, cyc);
    end else if (n == 1) begin
      a.cyc  = cyc;
      a.kind = bus.o_start_read_axi ? SR : bus.o_start_write_axi ? SW :
               bus.o_icache_done ? ICD : bus.o_dcache_rd_done ? DRD : DWD;
      a.addr = (a.kind <= SW) ? bus.o_addr_axi : '0;
      a.data = (a.kind == SW) ? bus.o_data_write_axi :
               (a.kind == ICD || a.kind == DRD) ? bus.o_read_block : '0;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kind=%0d in cycle %0d, required none", a.kind, cyc);
      end else begin
        e = q.pop_front();
        if (a.kind != e.kind || a.cyc != e.cyc || a.addr !== e.addr || a.data !== e.data) begin
          errors++;
          $display("FAIL event: got kind=%0d cyc=%0d addr=%0h data=%0h, required kind=%0d cyc=%0d addr=%0h data=%0h",
                   a.kind, a.cyc, a.addr, a.data, e.kind, e.cyc, e.addr, e.data);
        end
      end
    end
  end
  initial begin
    bus.i_icache_rd_req   = 1'b0;
    bus.i_icache_addr     = '0;
    bus.i_dcache_rd_req   = 1'b0;
    bus.i_dcache_wr_req   = 1'b0;
    bus.i_dcache_addr     = '0;
    bus.i_dcache_wr_block = '0;
    bus.i_data_read_axi   = JUNK;
    bus.i_read_last_axi   = 1'b0;
    bus.i_b_resp_axi      = 1'b0;
    #1 arst = 1'b1;
    #2;
    chk("reset_ctrl", {bus.o_busy, bus.o_protocol_err, bus.o_start_read_axi, bus.o_start_write_axi,
                       bus.o_icache_done, bus.o_dcache_rd_done, bus.o_dcache_wr_done}, '0);
    chk("reset_addr", bus.o_addr_axi, '0);
    chk("reset_wdata", bus.o_data_write_axi, '0);
    chk("reset_rblock", bus.o_read_block, '0);
    step();
    step();
    arst = 1'b0;
    // icache refill with unaligned address
    bus.i_icache_rd_req = 1'b1;
    bus.i_icache_addr   = 64'h0000_0000_0000_107C;
    serve(0, 64'h1040, '0, {64{8'hA5}}, 4, ICD);
    chk("busy_idle_after_ic", bus.o_busy, 1'b0);
    // write-back precedes its own refill
    bus.i_dcache_wr_req   = 1'b1;
    bus.i_dcache_rd_req   = 1'b1;
    bus.i_dcache_addr     = 64'h2000;
    bus.i_dcache_wr_block = {64{8'h5A}};
    serve(1, 64'h2000, {64{8'h5A}}, '0, 2, DWD);
    serve(0, 64'h2000, '0, {64{8'h3C}}, 2, DRD);
    chk("no_err_normal", bus.o_protocol_err, 1'b0);
    // icache vs dcache contention from a fresh reset
    arst = 1'b1;
    step();
    arst = 1'b0;
    bus.i_icache_rd_req = 1'b1;
    bus.i_icache_addr   = 64'h3000;
    bus.i_dcache_rd_req = 1'b1;
    bus.i_dcache_addr   = 64'h4010;
`ifdef ARB_ROUND_ROBIN_EN
    serve(0, 64'h4000, '0, {64{8'h11}}, 1, DRD);
    bus.i_dcache_rd_req = 1'b1;
    serve(0, 64'h3000, '0, {64{8'h22}}, 1, ICD);
    bus.i_icache_rd_req = 1'b1;
    serve(0, 64'h4000, '0, {64{8'h33}}, 1, DRD);
    serve(0, 64'h3000, '0, {64{8'h44}}, 1, ICD);
`else
    serve(0, 64'h4000, '0, {64{8'h11}}, 1, DRD);
    serve(0, 64'h3000, '0, {64{8'h22}}, 1, ICD);
`endif
    // stray write response while idle
    bus.i_b_resp_axi = 1'b1;
    step();
    bus.i_b_resp_axi = 1'b0;
    step();
    chk("err_set_idle", bus.o_protocol_err, 1'b1);
    bus.i_icache_rd_req = 1'b1;
    bus.i_icache_addr   = 64'h7000;
    serve(0, 64'h7000, '0, {64{8'h77}}, 1, ICD);
    chk("err_sticky", bus.o_protocol_err, 1'b1);
    // reset in WAIT of a dcache read
    bus.i_dcache_rd_req = 1'b1;
    bus.i_dcache_addr   = 64'h5055;
    push(SR, 64'h5040, '0);
    step();
    step();
    step();
    arst = 1'b1;
    #1;
    chk("arst_busy", bus.o_busy, 1'b0);
    chk("arst_err", bus.o_protocol_err, 1'b0);
    chk("arst_rblock", bus.o_read_block, '0);
    chk("arst_addr", bus.o_addr_axi, '0);
    step();
    step();
    arst = 1'b0;
    serve(0, 64'h5040, '0, {64{8'h99}}, 2, DRD);
    // request dropped mid-transfer still completes
    bus.i_icache_rd_req = 1'b1;
    bus.i_icache_addr   = 64'h6008;
    push(SR, 64'h6000, '0);
    step();
    step();
    bus.i_icache_rd_req = 1'b0;
    chk("addr_hold_wait", bus.o_addr_axi, 64'h6000);
    step();
    bus.i_read_last_axi = 1'b1;
    bus.i_data_read_axi = {64{8'hC3}};
    push(ICD, '0, {64{8'hC3}});
    step();
    bus.i_read_last_axi = 1'b0;
    bus.i_data_read_axi = JUNK;
    chk("busy_in_done", bus.o_busy, 1'b1);
    step();
    chk("busy_after_drop", bus.o_busy, 1'b0);
    repeat (4) step();
    chk("queue_drained", 512'(q.size()), '0);
    chk("rblock_hold", bus.o_read_block, {64{8'hC3}});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
